// File: rtl/axi_r_responder.sv
// AXI4 read responder: queues AR requests and answers each with len+1 R beats whose data is
// the beat address, so the read master can predict every beat.
module axi_r_responder #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  input  logic [2:0]           ar_size_i,
  input  logic [1:0]           ar_burst_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 busy_o,
  output logic [15:0]          done_cnt_o
);

  localparam int unsigned PtrWidth = $clog2(FifoDepth);
  localparam logic [PtrWidth:0] OccFull = (PtrWidth + 1)'(FifoDepth);

  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  logic [IdWidth-1:0]   fifo_id_q    [FifoDepth];
  logic [AddrWidth-1:0] fifo_addr_q  [FifoDepth];
  logic [7:0]           fifo_len_q   [FifoDepth];
  logic [2:0]           fifo_size_q  [FifoDepth];
  logic [1:0]           fifo_burst_q [FifoDepth];

  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrWidth:0]    occ_q, occ_d;

  logic [0:0]           state_q, state_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [7:0]           beats_q, beats_d;
  logic [2:0]           size_q, size_d;
  logic [1:0]           burst_q, burst_d;
  logic [15:0]          done_q, done_d;

  logic push, pop, hs, last_beat, fifo_nonempty, bad_burst;

  assign ar_ready_o    = (occ_q != OccFull);
  assign fifo_nonempty = (occ_q != '0);
  assign push          = ar_valid_i && ar_ready_o;
  assign hs            = (state_q == StSend) && r_ready_i;
  assign last_beat     = (beats_q == 8'd0);
  // Pop either to start from idle or to chain the next burst straight after a last beat.
  assign pop           = fifo_nonempty && ((state_q == StIdle) || (hs && last_beat));

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_id_q[wr_ptr_q]    <= ar_id_i;
      fifo_addr_q[wr_ptr_q]  <= ar_addr_i;
      fifo_len_q[wr_ptr_q]   <= ar_len_i;
      fifo_size_q[wr_ptr_q]  <= ar_size_i;
      fifo_burst_q[wr_ptr_q] <= ar_burst_i;
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + (PtrWidth + 1)'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - (PtrWidth + 1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    size_d  = size_q;
    burst_d = burst_q;
    done_d  = done_q;
    if (hs) begin
      if (!last_beat) begin
        beats_d = beats_q - 8'd1;
        if (burst_q == BurstIncr) begin
          addr_d = addr_q + (AddrWidth'(1) << size_q);
        end
      end else begin
        done_d  = done_q + 16'd1;
        state_d = StIdle;
      end
    end
    if (pop) begin
      state_d = StSend;
      id_d    = fifo_id_q[rd_ptr_q];
      addr_d  = fifo_addr_q[rd_ptr_q];
      beats_d = fifo_len_q[rd_ptr_q];
      size_d  = fifo_size_q[rd_ptr_q];
      burst_d = fifo_burst_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      state_q  <= StIdle;
      id_q     <= '0;
      addr_q   <= '0;
      beats_q  <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      done_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      occ_q   <= occ_d;
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      done_q  <= done_d;
    end
  end

  // WRAP and the reserved encoding both have bit 1 set.
  assign bad_burst  = burst_q[1];
  assign r_valid_o  = (state_q == StSend);
  assign r_id_o     = id_q;
  assign r_data_o   = bad_burst ? '0 : DataWidth'(addr_q);
  assign r_resp_o   = bad_burst ? RespSlverr : RespOkay;
  assign r_last_o   = (state_q == StSend) && last_beat;
  assign busy_o     = (state_q == StSend) || fifo_nonempty;
  assign done_cnt_o = done_q;

endmodule

// File: tb/tb_axi_r_responder.sv
// Directed self-checking bench for axi_r_responder with hand-computed expected beats.
module tb_axi_r_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ar_valid_i;
  logic        ar_ready_o;
  logic [3:0]  ar_id_i;
  logic [63:0] ar_addr_i;
  logic [7:0]  ar_len_i;
  logic [2:0]  ar_size_i;
  logic [1:0]  ar_burst_i;
  logic        r_valid_o;
  logic        r_ready_i;
  logic [3:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic        busy_o;
  logic [15:0] done_cnt_o;

  int checks = 0;
  int passed = 0;
  int exp_done = 0;

  axi_r_responder dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_o),
    .ar_id_i    (ar_id_i),
    .ar_addr_i  (ar_addr_i),
    .ar_len_i   (ar_len_i),
    .ar_size_i  (ar_size_i),
    .ar_burst_i (ar_burst_i),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i),
    .r_id_o     (r_id_o),
    .r_data_o   (r_data_o),
    .r_resp_o   (r_resp_o),
    .r_last_o   (r_last_o),
    .busy_o     (busy_o),
    .done_cnt_o (done_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ar_ready"}, 64'(ar_ready_o), 64'd1);
    chk({tag, "_r_valid"},  64'(r_valid_o),  64'd0);
    chk({tag, "_r_last"},   64'(r_last_o),   64'd0);
    chk({tag, "_r_id"},     64'(r_id_o),     64'd0);
    chk({tag, "_r_data"},   r_data_o,        64'd0);
    chk({tag, "_r_resp"},   64'(r_resp_o),   64'd0);
    chk({tag, "_busy"},     64'(busy_o),     64'd0);
    chk({tag, "_done"},     64'(done_cnt_o), 64'd0);
  endtask

  // Presents one AR for a single cycle, expecting it to be accepted.
  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    ar_valid_i = 1'b1;
    ar_id_i    = id;
    ar_addr_i  = addr;
    ar_len_i   = len;
    ar_size_i  = size;
    ar_burst_i = burst;
    chk("ar_ready_on_send", 64'(ar_ready_o), 64'd1);
    step();
    ar_valid_i = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [3:0] id, input logic [63:0] data,
                             input logic [1:0] resp, input logic last);
    chk({tag, "_valid"}, 64'(r_valid_o), 64'd1);
    chk({tag, "_id"},    64'(r_id_o),    64'(id));
    chk({tag, "_data"},  r_data_o,       data);
    chk({tag, "_resp"},  64'(r_resp_o),  64'(resp));
    chk({tag, "_last"},  64'(r_last_o),  64'(last));
    step();
  endtask

  initial begin
    logic [63:0] wexp [4];
    int k;
    int cyc;

    rst_ni = 1'b0; ar_valid_i = 1'b0; ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0;
    ar_size_i = '0; ar_burst_i = '0; r_ready_i = 1'b0;
    #2;
    chk_reset_vals("reset");
    step(); step();
    rst_ni = 1'b1;
    step();
    chk_reset_vals("post_reset");

    // Single INCR burst, first beat two cycles after the AR handshake.
    r_ready_i = 1'b1;
    send_ar(4'd3, 64'h1000, 8'd3, 3'd3, 2'b01);
    chk("single_t1_valid", 64'(r_valid_o), 64'd0);
    chk("single_t1_busy",  64'(busy_o),    64'd1);
    step();
    expect_beat("single_b0", 4'd3, 64'h1000, 2'b00, 1'b0);
    expect_beat("single_b1", 4'd3, 64'h1008, 2'b00, 1'b0);
    expect_beat("single_b2", 4'd3, 64'h1010, 2'b00, 1'b0);
    expect_beat("single_b3", 4'd3, 64'h1018, 2'b00, 1'b1);
    exp_done++;
    chk("single_end_valid", 64'(r_valid_o),  64'd0);
    chk("single_end_busy",  64'(busy_o),     64'd0);
    chk("single_done",      64'(done_cnt_o), 64'(exp_done));

    // FIFO full: first AR is popped into the working regs, next four fill the FIFO.
    r_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) send_ar(4'(i), 64'(256 * (i + 1)), 8'd0, 3'd3, 2'b01);
    chk("full_ar_ready", 64'(ar_ready_o), 64'd0);
    chk("full_busy",     64'(busy_o),     64'd1);
    ar_valid_i = 1'b1; ar_id_i = 4'd5; ar_addr_i = 64'h600;
    step();
    chk("full_stall_ready", 64'(ar_ready_o), 64'd0);
    chk("full_stall_data",  r_data_o,        64'h100);
    r_ready_i = 1'b1;
    chk("full_pop_cycle_ready", 64'(ar_ready_o), 64'd0);
    expect_beat("fifo_b0", 4'd0, 64'h100, 2'b00, 1'b1);
    chk("full_reopen_ready", 64'(ar_ready_o), 64'd1);
    expect_beat("fifo_b1", 4'd1, 64'h200, 2'b00, 1'b1);
    ar_valid_i = 1'b0;
    // Push and pop coincided last cycle, so occupancy held at 3.
    chk("full_pushpop_ready", 64'(ar_ready_o), 64'd1);
    expect_beat("fifo_b2", 4'd2, 64'h300, 2'b00, 1'b1);
    expect_beat("fifo_b3", 4'd3, 64'h400, 2'b00, 1'b1);
    expect_beat("fifo_b4", 4'd4, 64'h500, 2'b00, 1'b1);
    expect_beat("fifo_b5", 4'd5, 64'h600, 2'b00, 1'b1);
    exp_done += 6;
    chk("fifo_end_valid", 64'(r_valid_o),  64'd0);
    chk("fifo_end_busy",  64'(busy_o),     64'd0);
    chk("fifo_done",      64'(done_cnt_o), 64'(exp_done));

    // Back-to-back single-beat bursts.
    send_ar(4'd7, 64'h10, 8'd0, 3'd2, 2'b01);
    send_ar(4'd8, 64'h20, 8'd0, 3'd2, 2'b01);
    expect_beat("b2b_0", 4'd7, 64'h10, 2'b00, 1'b1);
    expect_beat("b2b_1", 4'd8, 64'h20, 2'b00, 1'b1);
    exp_done += 2;
    chk("b2b_end_valid", 64'(r_valid_o), 64'd0);

    // FIXED burst holds the address.
    send_ar(4'd1, 64'h40, 8'd2, 3'd3, 2'b00);
    step();
    expect_beat("fixed_b0", 4'd1, 64'h40, 2'b00, 1'b0);
    expect_beat("fixed_b1", 4'd1, 64'h40, 2'b00, 1'b0);
    expect_beat("fixed_b2", 4'd1, 64'h40, 2'b00, 1'b1);
    exp_done++;

    // WRAP burst returns SLVERR with zero data.
    send_ar(4'd2, 64'h80, 8'd1, 3'd3, 2'b10);
    step();
    expect_beat("wrap_b0", 4'd2, 64'h0, 2'b10, 1'b0);
    expect_beat("wrap_b1", 4'd2, 64'h0, 2'b10, 1'b1);
    exp_done++;
    chk("types_done", 64'(done_cnt_o), 64'(exp_done));

    // Random stalls across the 64-bit address wrap.
    wexp[0] = 64'hFFFF_FFFF_FFFF_FFF0;
    wexp[1] = 64'hFFFF_FFFF_FFFF_FFF8;
    wexp[2] = 64'h0;
    wexp[3] = 64'h8;
    r_ready_i = 1'b0;
    send_ar(4'd9, 64'hFFFF_FFFF_FFFF_FFF0, 8'd3, 3'd3, 2'b01);
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 200) begin
      r_ready_i = 1'($urandom_range(0, 1));
      if (k > 0) chk("stall_valid_hold", 64'(r_valid_o), 64'd1);
      if (r_valid_o) begin
        chk("stall_data", r_data_o,        wexp[k]);
        chk("stall_id",   64'(r_id_o),     64'd9);
        chk("stall_last", 64'(r_last_o),   64'(k == 3));
        if (r_ready_i) k++;
      end
      step();
      cyc++;
    end
    chk("stall_beat_count", 64'(k), 64'd4);
    exp_done++;
    r_ready_i = 1'b0;
    chk("stall_end_valid", 64'(r_valid_o),  64'd0);
    chk("stall_done",      64'(done_cnt_o), 64'(exp_done));

    // Reset during the second of four beats.
    r_ready_i = 1'b1;
    send_ar(4'd4, 64'h2000, 8'd3, 3'd3, 2'b01);
    step();
    expect_beat("rst_b0", 4'd4, 64'h2000, 2'b00, 1'b0);
    chk("rst_b1_data", r_data_o, 64'h2008);
    rst_ni = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    step(); step();
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("after_reset_valid", 64'(r_valid_o), 64'd0);
      step();
    end
    chk("after_reset_busy", 64'(busy_o), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
